// File: rtl/led_walk_checker.sv
// led_walk_checker: watches a strobed LED bus for a single lit walker bouncing
// between the end positions, locks onto a regular walk and flags any break in it.
module led_walk_checker #(
  parameter int WIDTH      = 8,
  parameter int LOCK_COUNT = 4,
  parameter int CNT_W      = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_stb,
  input  logic [WIDTH-1:0]         i_led,
  output logic [$clog2(WIDTH)-1:0] o_pos,
  output logic                     o_dir,
  output logic                     o_locked,
  output logic                     o_err,
  output logic [CNT_W-1:0]         o_sweeps,
  output logic [CNT_W-1:0]         o_errcnt
);

  localparam int POS_W = $clog2(WIDTH);
  localparam logic [POS_W-1:0] POS_ZERO    = {POS_W{1'b0}};
  localparam logic [POS_W-1:0] POS_ONE     = POS_W'(1);
  localparam logic [POS_W-1:0] POS_LAST    = POS_W'(WIDTH - 1);
  localparam logic [3:0]       MATCH_ONE   = 4'd1;
  localparam logic [3:0]       LOCK_TARGET = 4'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    TRACK   = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  function automatic logic is_onehot(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] vm1;
    vm1 = v - {{(WIDTH-1){1'b0}}, 1'b1};
    return (v != {WIDTH{1'b0}}) && ((v & vm1) == {WIDTH{1'b0}});
  endfunction

  // Index of the lit bit; only meaningful when the input is one-hot.
  function automatic logic [POS_W-1:0] onehot_index(input logic [WIDTH-1:0] v);
    logic [POS_W-1:0] idx;
    idx = POS_ZERO;
    for (int k = 0; k < WIDTH; k++) begin
      idx = idx | ({POS_W{v[k]}} & POS_W'(k));
    end
    return idx;
  endfunction

  function automatic logic [POS_W-1:0] expected_pos(input logic [POS_W-1:0] pos,
                                                    input logic             dir);
    logic [POS_W-1:0] res;
    if (!dir) begin
      res = (pos == POS_LAST) ? (POS_LAST - POS_ONE) : (pos + POS_ONE);
    end else begin
      res = (pos == POS_ZERO) ? POS_ONE : (pos - POS_ONE);
    end
    return res;
  endfunction

  // Extended width keeps pos+1 from wrapping onto position 0.
  function automatic logic is_adjacent(input logic [POS_W-1:0] a,
                                       input logic [POS_W-1:0] b);
    return ({1'b0, b} == ({1'b0, a} + {1'b0, POS_ONE})) ||
           ({1'b0, a} == ({1'b0, b} + {1'b0, POS_ONE}));
  endfunction

  state_t           state_r, state_n;
  logic [POS_W-1:0] pos_r, pos_n;
  logic             dir_r, dir_n;
  logic             dir_known_r, dir_known_n;
  logic [3:0]       match_r, match_n;
  logic             locked_r;
  logic             err_r, err_n;
  logic [CNT_W-1:0] sweeps_r, sweeps_n;
  logic [CNT_W-1:0] errcnt_r, errcnt_n;

  logic             valid_s;
  logic [POS_W-1:0] new_pos_s;
  logic [POS_W-1:0] exp_pos_s;
  logic             track_hit_s;
  logic             lock_hit_s;

  assign valid_s     = is_onehot(i_led);
  assign new_pos_s   = onehot_index(i_led);
  assign exp_pos_s   = expected_pos(pos_r, dir_r);
  assign track_hit_s = valid_s && (dir_known_r ? (new_pos_s == exp_pos_s)
                                               : is_adjacent(pos_r, new_pos_s));
  assign lock_hit_s  = valid_s && (new_pos_s == exp_pos_s);

  // Next state, position/direction and counters for the current sample.
  always_comb begin
    state_n     = state_r;
    pos_n       = pos_r;
    dir_n       = dir_r;
    dir_known_n = dir_known_r;
    match_n     = match_r;
    err_n       = 1'b0;
    sweeps_n    = sweeps_r;
    errcnt_n    = errcnt_r;
    if (i_stb) begin
      case (state_r)
        ACQUIRE: begin
          dir_known_n = 1'b0;
          match_n     = 4'd0;
          if (valid_s) begin
            pos_n   = new_pos_s;
            state_n = TRACK;
          end else begin
            state_n = ACQUIRE;
          end
        end
        TRACK: begin
          if (track_hit_s) begin
            pos_n       = new_pos_s;
            dir_n       = (new_pos_s < pos_r);
            dir_known_n = 1'b1;
            match_n     = match_r + MATCH_ONE;
            if ((match_r + MATCH_ONE) == LOCK_TARGET) begin
              state_n = LOCKED;
            end else begin
              state_n = TRACK;
            end
          end else if (valid_s) begin
            pos_n       = new_pos_s;
            dir_known_n = 1'b0;
            match_n     = 4'd0;
            state_n     = TRACK;
          end else begin
            dir_known_n = 1'b0;
            match_n     = 4'd0;
            state_n     = ACQUIRE;
          end
        end
        LOCKED: begin
          if (lock_hit_s) begin
            pos_n = new_pos_s;
            dir_n = (new_pos_s < pos_r);
            if (new_pos_s == POS_ZERO) begin
              sweeps_n = sweeps_r + CNT_ONE;
            end else begin
              sweeps_n = sweeps_r;
            end
          end else begin
            // A broken walk is reported once, then re-acquired from this sample.
            err_n       = 1'b1;
            errcnt_n    = (errcnt_r == CNT_MAX) ? errcnt_r : (errcnt_r + CNT_ONE);
            dir_known_n = 1'b0;
            match_n     = 4'd0;
            if (valid_s) begin
              pos_n   = new_pos_s;
              state_n = TRACK;
            end else begin
              state_n = ACQUIRE;
            end
          end
        end
        default: begin
          state_n     = ACQUIRE;
          dir_known_n = 1'b0;
          match_n     = 4'd0;
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r     <= ACQUIRE;
      pos_r       <= POS_ZERO;
      dir_r       <= 1'b0;
      dir_known_r <= 1'b0;
      match_r     <= 4'd0;
      locked_r    <= 1'b0;
      err_r       <= 1'b0;
      sweeps_r    <= {CNT_W{1'b0}};
      errcnt_r    <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_n;
      pos_r       <= pos_n;
      dir_r       <= dir_n;
      dir_known_r <= dir_known_n;
      match_r     <= match_n;
      locked_r    <= (state_n == LOCKED);
      err_r       <= err_n;
      sweeps_r    <= sweeps_n;
      errcnt_r    <= errcnt_n;
    end
  end

  assign o_pos    = pos_r;
  assign o_dir    = dir_r;
  assign o_locked = locked_r;
  assign o_err    = err_r;
  assign o_sweeps = sweeps_r;
  assign o_errcnt = errcnt_r;

endmodule

// File: doc/led_walk_checker.md
LED_WALK_CHECKER -- requirements
Module: led_walk_checker

Interface
REQ-001 Parameter WIDTH, default 8: number of LED lines observed (WIDTH >= 3).
REQ-002 Parameter LOCK_COUNT, default 4: consecutive correct steps needed to declare lock (1..15).
REQ-003 Parameter CNT_W, default 16: width of the sweep and error counters.
REQ-004 Port i_clk  input  1: single clock; all state changes on its rising edge.
REQ-005 Port i_reset  input  1: reset, synchronous and active-high.
REQ-006 Port i_stb  input  1: sample qualifier; i_led is evaluated only in cycles with i_stb=1.
REQ-007 Port i_led  input  WIDTH: observed LED bus, bit k lit = walker position k.
REQ-008 Port o_pos  output  ceil(log2(WIDTH)): position of the last accepted sample.
REQ-009 Port o_dir  output  1: direction of the last accepted step; 0 = upward (k to k+1), 1 = downward.
REQ-010 Port o_locked  output  1: high while in the LOCKED state.
REQ-011 Port o_err  output  1: one-cycle pulse per rejected sample while LOCKED.
REQ-012 Port o_sweeps  output  CNT_W: completed round trips counted while locked; wraps modulo 2^CNT_W.
REQ-013 Port o_errcnt  output  CNT_W: count of o_err pulses; saturates at all-ones.

Function
REQ-014 All outputs are registered; the response to a strobed sample appears in the cycle after i_stb=1.
REQ-015 A sample is valid only if exactly one bit of i_led is set; zero or multi-hot samples are invalid.
REQ-016 With i_stb=0, no state, output, or counter changes, and o_err is 0.
REQ-017 Expected next position: dir=0 gives pos+1, or WIDTH-2 when pos=WIDTH-1; dir=1 gives pos-1, or 1 when pos=0.
REQ-018 After every accepted step, o_dir is the sign of that step; a step into WIDTH-1 sets o_dir=0 and a step into 0 sets o_dir=1.
REQ-019 States: ACQUIRE, TRACK, LOCKED. Reset state is ACQUIRE, with a match counter of 0 and direction marked unknown.
REQ-020 ACQUIRE: a valid sample loads o_pos, marks direction unknown, clears the match counter, and moves to TRACK. An invalid sample stays in ACQUIRE.
REQ-021 TRACK, direction unknown: a valid sample with |new-pos| = 1 is a match, sets direction from the step, and increments the match counter.
REQ-022 TRACK, direction known: only the REQ-017 expected position is a match, and it increments the match counter.
REQ-023 TRACK: when the match counter reaches LOCK_COUNT, the state moves to LOCKED.
REQ-024 TRACK: any non-matching sample is handled as in ACQUIRE. A valid sample re-seeds TRACK at the new position. An invalid sample returns to ACQUIRE. No o_err is raised.
REQ-025 LOCKED: a sample equal to the expected position updates o_pos and o_dir and stays LOCKED.
REQ-026 LOCKED: any other sample (wrong position, repeat, or invalid) causes all of the following:
  - o_err pulses for one cycle;
  - o_errcnt increments (saturating);
  - o_locked clears;
  - the sample is handled as in ACQUIRE.
REQ-027 o_sweeps increments on each accepted LOCKED sample at position 0, i.e. once per completed round trip.
REQ-028 A repeated identical pattern is never a match.
REQ-029 Counter update and state transition for the same sample take effect in the same cycle.

Reset
REQ-030 When i_reset=1 on a clock edge, the following take effect the next cycle regardless of i_stb:
  - state becomes ACQUIRE, with the match counter at 0 and direction unknown;
  - o_pos=0, o_dir=0, o_locked=0, o_err=0, o_sweeps=0, o_errcnt=0.
REQ-031 Reset overrides any sample presented in the same cycle, including reset while LOCKED.

Verification (WIDTH=8, LOCK_COUNT=4, CNT_W=16)
REQ-032 Lock-up: after reset, strobe 01,02,04,08,10 on consecutive cycles -> o_locked=1 the cycle after 0x10, with o_pos=4, o_dir=0, o_err never asserted.
REQ-033 Bounce and sweep: continue the REQ-032 walk with 20,40,80,40,20,10,08,04,02,01 -> o_dir=1 from the sample 0x40 after 0x80, o_sweeps=1 after 0x01, o_locked stays 1.
REQ-034 Invalid pattern while locked: strobe 0x18 -> o_err high for exactly one cycle, o_errcnt=1, o_locked=0. A following 0x00 keeps the block in ACQUIRE with no further o_err.
REQ-035 Skip while locked: locked at pos 3 with dir=0, strobe 0x20 -> o_err pulse, o_pos=5. Then 0x10,0x08,0x04,0x02 -> re-lock with o_dir=1 after 4 matches.
REQ-036 Strobe gating and counter limits: toggle i_led freely with i_stb=0 -> all outputs unchanged. Force o_errcnt to 0xFFFF plus one more error -> o_errcnt stays 0xFFFF.
REQ-037 Reset mid-operation: assert i_reset while locked at pos 6 with i_stb=1 and i_led=0x80 -> next cycle every output is 0 and the state is ACQUIRE.
